// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with registered result and borrow
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        bit_d     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = bit_d;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        busy_d   = busy_q;
        done_d   = done_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // Result registers load only on the final slice so they hold otherwise
                if (cnt_q == LAST) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    diff_d   = res_shift;
                    borrow_d = br_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized self-checking bench for serial_sub (WIDTH=8 and WIDTH=1)
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         borrow1;

    int errors = 0;
    int checks = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned subtraction modulo 2^W, borrow when minuend is smaller
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = (int'(x) + (1 << W) - int'(y)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    // Issues one start pulse and observes the following WIDTH+4 cycles
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb,
                         output logic [W-1:0] d, output logic br, output int nbusy,
                         output int ndone, output int done_at, output bit overlap);
        d = 'x;
        br = 1'bx;
        nbusy = 0;
        ndone = 0;
        done_at = -1;
        overlap = 1'b0;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
                d = diff;
                br = borrow;
            end
            if (busy && done) overlap = 1'b1;
            if (disturb) begin
                a = W'($urandom);
                b = W'($urandom);
                start = (i <= W) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        a = '0;
        b = '0;
        a1 = '0;
        b1 = '0;
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
                     busy, done, diff, borrow);
        end
        checks++;
        if ({busy1, done1, diff1, borrow1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_w1: got %b%b%b%b, want 0000", busy1, done1, diff1, borrow1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed;
        logic [W-1:0] av [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
        logic [W-1:0] bv [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
        logic [W-1:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] d;
        logic br;
        int nb, nd, da;
        bit ov;
        for (int k = 0; k < 4; k++) begin
            do_op(av[k], bv[k], 1'b0, d, br, nb, nd, da, ov);
            checks++;
            if (nb !== W || nd !== 1 || da !== W || ov) begin
                errors++;
                $display("FAIL directed_timing[%0d]: busy=%0d done=%0d at=%0d overlap=%0d, want %0d/1/%0d/0",
                         k, nb, nd, da, ov, W, W);
            end
            checks++;
            if (d !== ed[k] || br !== eb[k]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got diff=%h borrow=%b, want diff=%h borrow=%b",
                         k, d, br, ed[k], eb[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] av, bv, d;
        logic br;
        int nb, nd, da;
        bit ov;
        for (int k = 0; k < 20; k++) begin
            av = W'($urandom);
            bv = W'($urandom);
            do_op(av, bv, 1'b0, d, br, nb, nd, da, ov);
            checks++;
            if (nd !== 1 || d !== ref_diff(av, bv) || br !== ref_borrow(av, bv)) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h got done=%0d diff=%h borrow=%b, want 1 %h %b",
                         k, av, bv, nd, d, br, ref_diff(av, bv), ref_borrow(av, bv));
            end
        end
    endtask

    task automatic test_disturb;
        logic [W-1:0] av, bv, d;
        logic br;
        int nb, nd, da;
        bit ov;
        for (int k = 0; k < 6; k++) begin
            av = W'($urandom);
            bv = W'($urandom);
            do_op(av, bv, 1'b1, d, br, nb, nd, da, ov);
            checks++;
            if (nd !== 1 || nb !== W || da !== W || ov) begin
                errors++;
                $display("FAIL disturb_timing[%0d]: busy=%0d done=%0d at=%0d overlap=%0d, want %0d/1/%0d/0",
                         k, nb, nd, da, ov, W, W);
            end
            checks++;
            if (d !== ref_diff(av, bv) || br !== ref_borrow(av, bv)) begin
                errors++;
                $display("FAIL disturb_result[%0d]: got diff=%h borrow=%b, want diff=%h borrow=%b",
                         k, d, br, ref_diff(av, bv), ref_borrow(av, bv));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] av, bv, d;
        logic br;
        int nb, nd, da;
        bit ov;
        int seen;
        do_op(8'h00, 8'h01, 1'b0, d, br, nb, nd, da, ov);
        checks++;
        if (diff !== 8'hFF || borrow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_result: got diff=%h borrow=%b, want ff 1", diff, borrow);
        end
        a = 8'h5A;
        b = 8'h21;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_busy: got %b, want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b, want all 0",
                     busy, done, diff, borrow);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) seen++;
        end
        rst_n = 1'b1;
        av = W'($urandom);
        bv = W'($urandom);
        do_op(av, bv, 1'b0, d, br, nb, nd, da, ov);
        checks++;
        if (seen !== 0 || nd !== 1 || da !== W) begin
            errors++;
            $display("FAIL post_reset_timing: activity_in_reset=%0d done=%0d at=%0d, want 0/1/%0d",
                     seen, nd, da, W);
        end
        checks++;
        if (d !== ref_diff(av, bv) || br !== ref_borrow(av, bv)) begin
            errors++;
            $display("FAIL post_reset_result: got diff=%h borrow=%b, want diff=%h borrow=%b",
                     d, br, ref_diff(av, bv), ref_borrow(av, bv));
        end
    endtask

    // Start held high: operands presented every cycle, captured only at accept edges
    task automatic test_back_to_back;
        logic [W-1:0] av [40];
        logic [W-1:0] bv [40];
        int times[$];
        logic [W-1:0] dres[$];
        logic bres[$];
        logic [W-1:0] prev;
        int unstable;
        unstable = 0;
        prev = diff;
        for (int c = 0; c < 36; c++) begin
            av[c] = W'($urandom);
            bv[c] = W'($urandom);
            a = av[c];
            b = bv[c];
            start = (c < 30);
            if (done) begin
                times.push_back(c);
                dres.push_back(diff);
                bres.push_back(borrow);
            end else if (diff !== prev) begin
                unstable++;
            end
            prev = diff;
            tick();
        end
        start = 1'b0;
        checks++;
        if (times.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", times.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (times[k] !== 9 + k * (W + 2)) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: done at cycle %0d, want %0d", k, times[k],
                             9 + k * (W + 2));
                end
                checks++;
                if (dres[k] !== ref_diff(av[k*(W+2)], bv[k*(W+2)]) ||
                    bres[k] !== ref_borrow(av[k*(W+2)], bv[k*(W+2)])) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got diff=%h borrow=%b, want diff=%h borrow=%b",
                             k, dres[k], bres[k], ref_diff(av[k*(W+2)], bv[k*(W+2)]),
                             ref_borrow(av[k*(W+2)], bv[k*(W+2)]));
                end
            end
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL b2b_diff_stable: diff changed %0d times outside done, want 0", unstable);
        end
    endtask

    task automatic test_width1;
        int nd;
        logic dv, bv_o;
        int ea, eb;
        for (int v = 0; v < 4; v++) begin
            ea = v / 2;
            eb = v % 2;
            a1 = 1'(ea);
            b1 = 1'(eb);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            nd = 0;
            dv = 1'bx;
            bv_o = 1'bx;
            for (int i = 0; i < 4; i++) begin
                if (done1) begin
                    nd++;
                    dv = diff1;
                    bv_o = borrow1;
                end
                tick();
            end
            checks++;
            if (nd !== 1 || dv !== 1'((ea - eb + 2) % 2) || bv_o !== (ea < eb)) begin
                errors++;
                $display("FAIL width1[%0d%0d]: got done=%0d diff=%b borrow=%b, want 1 %0d %0d",
                         ea, eb, nd, dv, bv_o, (ea - eb + 2) % 2, ea < eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_disturb();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
